chunked_adder: RTL

Multi-cycle WIDTH-bit adder that sums two operands CHUNK bits per clock, carrying each chunk's carry-out into the next. It reuses a CHUNK-wide `cla` instance, trading latency for area. Sits between an operand source and a result consumer, with valid/ready handshakes on both sides. The full-width combinational `cla` is its golden reference in verification.

---
 rtl/chunked_adder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder that reuses one CHUNK-wide cla,
// adding CHUNK bits per clock and rippling the carry between chunks.
// Optional feature: define CHUNKED_ADDER_OVF_EN to add the registered
// signed-overflow output ovf.

module cla #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    logic [W-1:0] g;
    logic [W-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    // Carry chain built from generate/propagate terms, sum formed bit by bit
    always_comb begin
        logic c;
        c = cin;
        s = '0;
        for (int i = 0; i < W; i++) begin
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        cout = c;
    end
endmodule

module chunked_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic [KW-1:0]     k_q;
    logic              last;
    logic              accept;
    logic [CHUNK-1:0]  chunk_a;
    logic [CHUNK-1:0]  chunk_b;
    logic [CHUNK-1:0]  chunk_s;
    logic              chunk_co;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (k_q == KW'(NCHUNK - 1));

    // Current chunk of the latched operands
    assign chunk_a = a_q[k_q*CHUNK +: CHUNK];
    assign chunk_b = b_q[k_q*CHUNK +: CHUNK];

    cla #(.W(CHUNK)) u_cla (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .s    (chunk_s),
        .cout (chunk_co)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode: accept in IDLE, step chunks in ADD, wait for consumer in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ADD;
            ADD:     if (last)     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch; operands are free to change once accepted
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Chunk index, carry and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q     <= '0;
            carry_q <= 1'b0;
            s       <= '0;
            cout    <= 1'b0;
        end else begin
            if (accept) begin
                k_q     <= '0;
                carry_q <= cin;
            end else if (state_q == ADD) begin
                s[k_q*CHUNK +: CHUNK] <= chunk_s;
                carry_q               <= chunk_co;
                k_q                   <= last ? '0 : k_q + 1'b1;
                if (last) cout <= chunk_co;
            end
        end
    end

`ifdef CHUNKED_ADDER_OVF_EN
    // Signed overflow captured alongside the final chunk; the top sum bit is
    // the MSB of the chunk being written this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state_q == ADD && last) begin
            ovf <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (chunk_s[CHUNK-1] != a_q[WIDTH-1]);
        end
    end
`endif

endmodule
